alu_op_sequencer: RTL

- Byte-serial front end that drives the team's 8-bit combinational ALU.
- Collects a command byte and up to two operand bytes over a valid/ready stream.
- Presents A, B and sel to the ALU from registers, captures R, and returns the result over a valid/ready stream.
- Keeps an accumulator so commands can chain on the previous result. Sits between the chip I/O pins and the ALU.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_timeout.sv | 30 +++
 rtl/alu_op_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encoding, opcodes and opcode helpers for alu_op_sequencer
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_CMD,
    S_A,
    S_B,
    S_EXEC,
    S_OUT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_ROTL = 3'b100;
  localparam logic [2:0] OP_ROTR = 3'b101;

  function automatic logic is_unary(input logic [2:0] op);
    return (op == OP_ROTL) || (op == OP_ROTR);
  endfunction

  function automatic logic is_valid(input logic [2:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROTL, OP_ROTR};
  endfunction

endpackage

// File: rtl/alu_seq_timeout.sv
// rtl/alu_seq_timeout.sv - idle-cycle counter that flags expiry after TIMEOUT_CYCLES waiting cycles
module alu_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Expiry fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
  assign o_expire = (TIMEOUT_CYCLES > 0) && i_en && (r_cnt == CW'(LAST));

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - byte-serial command/operand front end driving an external 8-bit ALU
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int WIDTH          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_r,
  output logic             busy,
  output logic             timeout
);

  state_t           r_state;
  logic [2:0]       r_op;
  logic             r_err;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_sel;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;
  logic             r_out_valid;
  logic             r_timeout;

  logic       w_accept;
  logic       w_wait;
  logic       w_expire;
  logic [2:0] w_op;
  logic       w_chain;

  assign w_op     = in_data[2:0];
  assign w_chain  = in_data[3];
  assign w_wait   = (r_state == S_A) || (r_state == S_B);
  assign in_ready = (r_state == S_CMD) || w_wait;
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state != S_CMD);

  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign out_valid = r_out_valid;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign timeout   = r_timeout;

  alu_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (!w_wait || w_accept),
    .i_en    (w_wait && !w_accept),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CMD;
      r_op        <= '0;
      r_err       <= 1'b0;
      r_acc       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_CMD: begin
          if (w_accept) begin
            r_op      <= w_op;
            r_alu_sel <= w_op;
            r_alu_b   <= '0;
            r_err     <= !is_valid(w_op);
            if (!is_valid(w_op)) begin
              r_state <= S_EXEC;
            end else if (w_chain) begin
              r_alu_a <= r_acc;
              r_state <= is_unary(w_op) ? S_EXEC : S_B;
            end else begin
              r_state <= S_A;
            end
          end
        end
        S_A: begin
          if (w_accept) begin
            r_alu_a <= in_data;
            r_state <= is_unary(r_op) ? S_EXEC : S_B;
          end else if (w_expire) begin
            r_state   <= S_CMD;
            r_timeout <= 1'b1;
          end
        end
        S_B: begin
          if (w_accept) begin
            r_alu_b <= in_data;
            r_state <= S_EXEC;
          end else if (w_expire) begin
            r_state   <= S_CMD;
            r_timeout <= 1'b1;
          end
        end
        S_EXEC: begin
          // Invalid opcodes still report a result, but must not disturb the chain value.
          r_out_data  <= alu_r;
          r_out_err   <= r_err;
          r_out_valid <= 1'b1;
          if (!r_err) r_acc <= alu_r;
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_CMD;
          end
        end
        default: r_state <= S_CMD;
      endcase
    end
  end

endmodule
